// File: rtl/opsum_fifo_ctrl_if.sv
// Handshake bundle between the opsum drain controller, the opsum FIFO and the GLB write port.
// master = controller view, slave = FIFO/GLB side view.
interface opsum_fifo_ctrl_if;
   logic        opsum_fifo_reset_i;
   logic        opsum_need_push_i;
   logic [4:0]  opsum_push_num_i;
   logic        opsum_permit_pop_i;
   logic        opsum_fifo_empty_i;
   logic [15:0] opsum_fifo_pop_data_i;
   logic [31:0] opsum_glb_base_addr_i;

   logic        opsum_fifo_reset_o;
   logic        opsum_fifo_pop_en_o;
   logic        opsum_glb_write_req_o;
   logic [31:0] opsum_glb_write_addr_o;
   logic [31:0] opsum_glb_write_data_o;
   logic [3:0]  opsum_glb_write_web_o;
   logic        opsum_fifo_done_o;

   modport master (
      input  opsum_fifo_reset_i,
      input  opsum_need_push_i,
      input  opsum_push_num_i,
      input  opsum_permit_pop_i,
      input  opsum_fifo_empty_i,
      input  opsum_fifo_pop_data_i,
      input  opsum_glb_base_addr_i,
      output opsum_fifo_reset_o,
      output opsum_fifo_pop_en_o,
      output opsum_glb_write_req_o,
      output opsum_glb_write_addr_o,
      output opsum_glb_write_data_o,
      output opsum_glb_write_web_o,
      output opsum_fifo_done_o
   );

   modport slave (
      output opsum_fifo_reset_i,
      output opsum_need_push_i,
      output opsum_push_num_i,
      output opsum_permit_pop_i,
      output opsum_fifo_empty_i,
      output opsum_fifo_pop_data_i,
      output opsum_glb_base_addr_i,
      input  opsum_fifo_reset_o,
      input  opsum_fifo_pop_en_o,
      input  opsum_glb_write_req_o,
      input  opsum_glb_write_addr_o,
      input  opsum_glb_write_data_o,
      input  opsum_glb_write_web_o,
      input  opsum_fifo_done_o
   );
endinterface

// File: rtl/opsum_fifo_ctrl.sv
// Drains 16-bit psums from the opsum FIFO, packs them in pairs and writes each
// 32-bit word to the GLB at consecutive word addresses, then pulses done.
module opsum_fifo_ctrl (
   input logic               clk,
   input logic               rst_n,
   opsum_fifo_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next_state;

   logic [4:0]  r_count;
   logic        r_slot;
   logic [31:0] r_pack;
   logic [31:0] r_addr;
   logic [3:0]  r_web;

   logic        w_flush;
   logic        w_start;
   logic        w_pop_en;
   logic        w_write_req;
   logic        w_grant;
   logic        w_done;
   logic [31:0] w_base_aligned;

   assign w_flush        = bus.opsum_fifo_reset_i;
   assign w_base_aligned = bus.opsum_glb_base_addr_i & 32'hFFFF_FFFC;
   assign w_start        = (r_state == IDLE) && bus.opsum_need_push_i;
   assign w_grant        = w_write_req && bus.opsum_permit_pop_i;

   // NOTE: async active-low reset lives in the sensitivity list; the state
   // register uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_pop_en     = 1'b0;
      w_write_req  = 1'b0;
      w_done       = 1'b0;

      if (w_flush) begin
         w_next_state = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.opsum_need_push_i) begin
                  w_next_state = (bus.opsum_push_num_i == 5'd0) ? DONE : FILL;
               end
            end
            FILL: begin
               w_pop_en = !bus.opsum_fifo_empty_i;
               // Leave FILL once the high half is written or the task runs out.
               if (w_pop_en && (r_slot || (r_count == 5'd1))) begin
                  w_next_state = WRITE;
               end
            end
            WRITE: begin
               w_write_req = 1'b1;
               if (bus.opsum_permit_pop_i) begin
                  w_next_state = (r_count == 5'd0) ? DONE : FILL;
               end
            end
            DONE: begin
               w_done       = 1'b1;
               w_next_state = IDLE;
            end
            default: begin
               w_next_state = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= 5'd0;
         r_slot  <= 1'b0;
         r_pack  <= 32'd0;
         r_addr  <= 32'd0;
         r_web   <= 4'd0;
      end else if (w_flush) begin
         r_count <= 5'd0;
         r_slot  <= 1'b0;
         r_pack  <= 32'd0;
         r_addr  <= 32'd0;
         r_web   <= 4'd0;
      end else if (w_start) begin
         r_count <= bus.opsum_push_num_i;
         r_addr  <= w_base_aligned;
         r_slot  <= 1'b0;
         r_pack  <= 32'd0;
      end else if (w_pop_en) begin
         if (r_slot) begin
            r_pack[31:16] <= bus.opsum_fifo_pop_data_i;
         end else begin
            r_pack[15:0]  <= bus.opsum_fifo_pop_data_i;
         end
         r_count <= r_count - 5'd1;
         r_slot  <= ~r_slot;
         // A low-half pop that ends FILL leaves an odd final psum.
         r_web   <= r_slot ? 4'b1111 : 4'b0011;
      end else if (w_grant) begin
         r_addr <= r_addr + 32'd4;
         r_pack <= 32'd0;
         r_slot <= 1'b0;
      end
   end

   assign bus.opsum_fifo_reset_o     = bus.opsum_fifo_reset_i;
   assign bus.opsum_fifo_pop_en_o    = w_pop_en;
   assign bus.opsum_glb_write_req_o  = w_write_req;
   assign bus.opsum_glb_write_addr_o = r_addr;
   assign bus.opsum_glb_write_data_o = r_pack;
   assign bus.opsum_glb_write_web_o  = r_web;
   assign bus.opsum_fifo_done_o      = w_done;

endmodule

// File: doc/opsum_fifo_ctrl.md
OPSUM_FIFO_CTRL -- requirements
Module: opsum_fifo_ctrl

Interface
REQ-001 Parameters: none; widths are fixed as listed below.
REQ-002 clk  in  1  single clock; every register is updated on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 opsum_fifo_reset_i  in  1  synchronous flush request.
REQ-005 opsum_need_push_i  in  1  single-cycle start pulse; sampled only in IDLE.
REQ-006 opsum_push_num_i  in  5  number of 16-bit psums to drain, range 0..31.
REQ-007 opsum_permit_pop_i  in  1  GLB write grant.
REQ-008 opsum_fifo_empty_i  in  1  opsum FIFO empty flag.
REQ-009 opsum_fifo_pop_data_i  in  16  FIFO head data; first-word-fall-through, so it is valid in the same cycle as pop_en.
REQ-010 opsum_glb_base_addr_i  in  32  GLB byte address of the first write; sampled together with the start pulse.
REQ-011 opsum_fifo_reset_o  out  1  flush to the FIFO; equals opsum_fifo_reset_i combinationally.
REQ-012 opsum_fifo_pop_en_o  out  1  pop strobe to the FIFO.
REQ-013 opsum_glb_write_req_o  out  1  GLB write request.
REQ-014 opsum_glb_write_addr_o  out  32  GLB write byte address, always word-aligned.
REQ-015 opsum_glb_write_data_o  out  32  packed write data: {psum_hi, psum_lo}.
REQ-016 opsum_glb_write_web_o  out  4  byte-enable mask, active-high.
REQ-017 opsum_fifo_done_o  out  1  one-cycle pulse marking completion of a task.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, FILL, WRITE, DONE.
REQ-019 IDLE + need_push: latch remaining count = push_num and addr = base_addr.
 - count == 0: go to DONE.
 - count != 0: go to FILL and clear the pack slot to "low half".
REQ-020 In FILL, pop_en SHALL equal !empty_i; pop_en SHALL never assert while empty_i = 1.
REQ-021 Each FILL pop SHALL:
 - write pop_data into the current half (low half first, then high half);
 - decrement remaining count;
 - toggle the pack slot.
REQ-022 FILL SHALL transition to WRITE in the cycle after a pop that fills the high half, or a pop that makes remaining count 0.
REQ-023 WRITE: write_req = 1, with addr, data and web held stable until the cycle in which permit_pop_i = 1; pop_en = 0 throughout WRITE.
REQ-024 Web value:
 - full word: web = 4'b1111;
 - odd final psum (low half only): web = 4'b0011 and data[31:16] = 16'h0000.
REQ-025 On a granted write: addr += 4 (mod 2^32); clear the pack register to 0; go to DONE if remaining count == 0, else go to FILL.
REQ-026 DONE: done_o = 1 for exactly one cycle, then go to IDLE.
REQ-027 need_push SHALL be ignored in every state other than IDLE.
REQ-028 Outside WRITE, write_req SHALL be 0, and write_addr/write_data/write_web SHALL show the held register values.
REQ-029 When reset_i = 1 in any state, the FSM SHALL go to IDLE on the next edge.
 - Count, pack register, pack slot and addr are cleared.
 - No pop or write is issued in that cycle.
 - done_o is not pulsed.
 - reset_i takes priority over need_push and over permit_pop_i.
REQ-030 Latency from the start pulse to the first pop is 1 cycle if the FIFO is non-empty. Minimum cost is 3 cycles per full word: pop, pop, write with immediate grant.

Reset
REQ-031 While rst_n = 0:
 - state = IDLE;
 - pop_en, write_req and done_o = 0;
 - write_addr, write_data and web = 0;
 - count, pack slot and pack register = 0.
REQ-032 After rst_n deasserts, the first start pulse SHALL be accepted on the first rising edge.

Verification
REQ-033 Start with base 0x1000, num 6, FIFO holding 6 psums 0x0001..0x0006, permit held at 1.
 - Response: writes {0002,0001}@0x1000, {0004,0003}@0x1004, {0006,0005}@0x1008, all web 1111.
 - Then one done pulse, then IDLE.
REQ-034 Num 5, same setup.
 - Response: third write is 0x00000005 @0x1008 with web 0011.
 - Exactly 5 pops are issued.
REQ-035 Num 0.
 - Response: done_o pulses 1 cycle after the start pulse; no pop and no write_req occur.
REQ-036 FIFO empty for 4 cycles mid-word, then refilled.
 - Response: pop_en stays 0 while empty, and the packed data is unchanged.
 - Permit low for 3 cycles in WRITE: write_req, addr, data and web are held constant, and exactly one write completes.
REQ-037 reset_i pulsed during WRITE of word 2, then a new start with base 0x2000, num 2.
 - Response: no write of the old word occurs, reset_o mirrors reset_i, and no done pulse is seen for the aborted task.
 - New write {p1,p0}@0x2000, then done.
REQ-038 rst_n asserted mid-FILL.
 - Response: all outputs go to 0 immediately (asynchronous).
 - Next start operates correctly from IDLE.
